// File: rtl/wisc_pipe_pkg.sv
// Shared types for the WISC pipeline hazard controller: scoreboard entry,
// halt sequencer states and the forward-select width helper.
package wisc_pipe_pkg;

  // Scoreboard entries carry a fixed-width register tag so the struct can be
  // shared across instances; NREG up to 256 is supported.
  localparam int unsigned RD_MAXW = 8;

  typedef struct packed {
    logic               valid;
    logic [RD_MAXW-1:0] rd;
    logic               wr;
    logic               ld;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_t;

  // Width of a forward select able to encode 0 (register file) .. stages.
  function automatic int unsigned sel_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/sb_src_lookup.sv
// Youngest-producer finder for one source operand: returns the lowest stage
// index holding a valid writer of rs_i, plus whether that writer is a load.
module sb_src_lookup
  import wisc_pipe_pkg::*;
#(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned RW       = 4,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned SELW     = 2
) (
  input  sb_entry_t       sb_i [STAGES],
  input  logic [RW-1:0]   rs_i,
  input  logic            use_i,
  output logic            hit_o,
  output logic [SELW-1:0] k_o,
  output logic            ld_o
);

  logic zero_src;

  // Scan oldest to youngest so the youngest (smallest k) match wins.
  always_comb begin
    hit_o    = 1'b0;
    k_o      = '0;
    ld_o     = 1'b0;
    zero_src = (ZERO_REG != 0) && (rs_i == '0);
    if (use_i && !zero_src) begin
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
        if (sb_i[i].valid && sb_i[i].wr && (sb_i[i].rd == RD_MAXW'(rs_i))) begin
          hit_o = 1'b1;
          k_o   = SELW'(i + 1);
          ld_o  = sb_i[i].ld;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the WISC in-order pipeline. Tracks
// in-flight writers in a per-stage scoreboard beside ID and sequences the
// halt drain.
//
// state  | meaning
// RUN    | normal issue, hazard logic active
// DRAIN  | HLT issued, waiting STAGES cycles for the pipe to empty
// HALTED | pipe empty after HLT, held until reset
module pipe_hazard_ctrl
  import wisc_pipe_pkg::*;
#(
  parameter  int unsigned NREG     = 16,
  parameter  int unsigned STAGES   = 3,
  parameter  int unsigned LOAD_LAT = 2,
  parameter  int unsigned FWD_EN   = 1,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned RW       = $clog2(NREG),
  localparam int unsigned SELW     = sel_width(STAGES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic            id_rs1_use,
  input  logic            id_rs2_use,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_wr,
  input  logic            id_is_load,
  input  logic            id_is_halt,
  input  logic            redirect,
  output logic            stall,
  output logic            pc_wen,
  output logic            if_id_wen,
  output logic            bubble_id_ex,
  output logic            flush_if_id,
  output logic [SELW-1:0] fwd_sel_a,
  output logic [SELW-1:0] fwd_sel_b,
  output logic            draining,
  output logic            halted
);

  sb_entry_t       sb_q [STAGES];
  sb_entry_t       new_entry;
  halt_state_t     state_q, state_d;
  logic [SELW-1:0] cnt_q, cnt_d;
  logic            run, issue;
  logic            hit_a, hit_b, ld_a, ld_b, hz_a, hz_b;
  logic [SELW-1:0] k_a, k_b;

  assign run = (state_q == RUN);

  sb_src_lookup #(
    .STAGES(STAGES), .RW(RW), .ZERO_REG(ZERO_REG), .SELW(SELW)
  ) u_lookup_a (
    .sb_i(sb_q), .rs_i(id_rs1), .use_i(id_rs1_use),
    .hit_o(hit_a), .k_o(k_a), .ld_o(ld_a)
  );

  sb_src_lookup #(
    .STAGES(STAGES), .RW(RW), .ZERO_REG(ZERO_REG), .SELW(SELW)
  ) u_lookup_b (
    .sb_i(sb_q), .rs_i(id_rs2), .use_i(id_rs2_use),
    .hit_o(hit_b), .k_o(k_b), .ld_o(ld_b)
  );

  // Hazard decision and forward selects; without forwarding every producer
  // short of writeback blocks, since the register file bypasses the WB write.
  always_comb begin
    hz_a      = 1'b0;
    hz_b      = 1'b0;
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    if (FWD_EN != 0) begin
      hz_a = hit_a & ld_a & (int'(k_a) < int'(LOAD_LAT));
      hz_b = hit_b & ld_b & (int'(k_b) < int'(LOAD_LAT));
      if (run) begin
        fwd_sel_a = hit_a ? k_a : '0;
        fwd_sel_b = hit_b ? k_b : '0;
      end
    end else begin
      hz_a = hit_a & (int'(k_a) < int'(STAGES));
      hz_b = hit_b & (int'(k_b) < int'(STAGES));
    end
    stall = id_valid & run & (hz_a | hz_b);
  end

  assign issue     = id_valid & ~stall & run;
  assign new_entry = '{valid: 1'b1, rd: RD_MAXW'(id_rd), wr: id_wr, ld: id_is_load};

  // Scoreboard shift: issued instruction enters stage 1, everything ages by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(STAGES); k++) sb_q[k] <= '0;
    end else begin
      sb_q[0] <= issue ? new_entry : '0;
      for (int k = 1; k < int'(STAGES); k++) sb_q[k] <= sb_q[k-1];
    end
  end

  // Halt sequencer state and drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: counter loads STAGES-1 so HALTED lands STAGES edges after issue.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (issue && id_is_halt) begin
          state_d = DRAIN;
          cnt_d   = SELW'(STAGES - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = HALTED;
        else             cnt_d   = cnt_q - SELW'(1);
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // A halt in ID wins over a simultaneous redirect.
  assign pc_wen       = run & ~stall;
  assign if_id_wen    = run & ~stall;
  assign bubble_id_ex = stall | ~run;
  assign flush_if_id  = redirect & id_valid & ~id_is_halt & ~stall & run;
  assign draining     = (state_q == DRAIN);
  assign halted       = (state_q == HALTED);

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised stall/flush/forward controller for the WISC in-order pipeline. It generalises the core's fixed hazard and forwarding logic to any pipeline depth, load latency and forwarding mode. It sits beside the ID stage and tracks in-flight register writers in a per-stage scoreboard. Each cycle it drives the PC and IF/ID enables, ID/EX bubble insertion, IF/ID flush, per-operand forward selects and a halt drain sequence.

## Interface
- `NREG`, 16: architectural register count; `RW = $clog2(NREG)`
- `STAGES`, 3: tracked post-decode stages, indexed 1..STAGES (1 = EX, STAGES = WB)
- `LOAD_LAT`, 2: lowest stage index from which a load result is forwardable
- `FWD_EN`, 1: 1 = forwarding enabled; 0 = stall until writeback
- `ZERO_REG`, 1: 1 = register 0 is hardwired zero and never creates a hazard
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `id_valid` in 1: ID holds a valid instruction
- `id_rs1`, `id_rs2` in RW: source registers
- `id_rs1_use`, `id_rs2_use` in 1: the source is actually read
- `id_rd` in RW: destination register
- `id_wr` in 1: the instruction writes `id_rd`
- `id_is_load` in 1: the instruction is LW
- `id_is_halt` in 1: the instruction is HLT
- `redirect` in 1: the branch in ID is taken
- `stall` out 1: data hazard; hold PC and IF/ID
- `pc_wen`, `if_id_wen` out 1: enables for the PC register and the IF/ID register
- `bubble_id_ex` out 1: load a NOP into ID/EX
- `flush_if_id` out 1: clear IF/ID
- `fwd_sel_a`, `fwd_sel_b` out `SELW = $clog2(STAGES+1)`: 0 = register file; k = producer currently in stage k
- `draining` out 1: halt issued, pipeline emptying
- `halted` out 1: pipeline empty after HLT

## Operation
- Scoreboard: `STAGES` entries of {valid, rd, wr, ld}.
  - Every cycle entry[k] <= entry[k-1] for k ≥ 2.
  - entry[1] <= ID instruction when `issue = id_valid & ~stall & state==RUN`; otherwise a bubble (valid=0).
- Source match, evaluated per operand with `use=1`:
  - A match is the smallest k with valid & wr & rd==rs.
  - If `ZERO_REG=1`, a source of 0 never matches.
- With `FWD_EN=1`:
  - `stall` = any match whose entry has ld=1 and k < LOAD_LAT.
  - `fwd_sel` = matched k, or 0 if there is no match.
- With `FWD_EN=0`:
  - `stall` = any match with k < STAGES. The register file bypasses writes internally.
  - `fwd_sel` is always 0.
- `stall` is qualified by `id_valid` and `state==RUN`.
- Halt FSM:
  - RUN -> DRAIN when `issue & id_is_halt`.
  - DRAIN counts down `STAGES` cycles, then goes to HALTED.
  - HALTED is terminal until reset.
  - In DRAIN and HALTED all `id_*` inputs and `redirect` are ignored.
- Output equations:
  - `pc_wen = if_id_wen = (state==RUN) & ~stall`.
  - `bubble_id_ex = stall | (state!=RUN)`.
  - `flush_if_id = redirect & id_valid & ~stall & (state==RUN)`. A stalled branch never redirects; it redirects on the cycle it issues.
  - `draining = (state==DRAIN)`; `halted = (state==HALTED)`.
- Same-cycle `redirect` with `id_is_halt` cannot occur (same ID instruction). The halt takes priority.

## Timing
- Reset (`rst`=0, asynchronous):
  - All entries invalid, state RUN, counter 0.
  - Outputs: `stall`=0, `pc_wen`=`if_id_wen`=1, `bubble_id_ex`=0, `flush_if_id`=0, `fwd_sel_*`=0, `draining`=0, `halted`=0.
- Reset asserted mid-drain returns to RUN immediately, with no glitch on `halted` after deassertion.
- All hazard outputs are combinational from the ID inputs and the registered scoreboard. There is zero-cycle decision latency; the scoreboard updates at the next edge.
- Load-use stall length: `LOAD_LAT - k` cycles for a producer currently at stage k. With defaults, LW immediately followed by a dependent instruction stalls 1 cycle.
- `halted` rises exactly `STAGES` cycles after the HLT issue edge.

## Structure
- Shared package `wisc_pipe_pkg`:
  - `sb_entry_t` struct {valid, rd, wr, ld}.
  - `halt_state_t` enum {RUN, DRAIN, HALTED}.
  - `SELW` helper function.
- Sub-module `sb_src_lookup`: youngest-match priority finder returning {hit, k, ld}, instantiated once per source operand.
- The scoreboard shift register and the FSM live in the top module.

## Test plan
- LW R3 then ADD R4,R3,R5 (defaults) -> `stall`=1 for 1 cycle with `bubble_id_ex`=1, then `fwd_sel_a`=2.
- ADD R3 then SUB R6,R3,R3 -> no stall; `fwd_sel_a`=`fwd_sel_b`=1.
- `FWD_EN=0`, ADD R3 then dependent -> `stall` for 2 cycles (STAGES-1), then released with `fwd_sel`=0.
- Writer to R0, then a reader of R0 with `ZERO_REG=1` -> no stall, `fwd_sel`=0.
- Taken branch dependent on LW (`redirect`=1) -> `flush_if_id`=0 while stalled, then 1 on the issue cycle.
- HLT issued -> `pc_wen`=0 and `draining`=1 the next cycle, `halted`=1 after 3 cycles; `rst`=0 mid-drain -> RUN with all outputs at their reset values.
